// File: rtl/dsp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_sched_pkg
//  Purpose  : Shared types and default widths for the DSP frame scheduler.
//             Holds the scheduler state encoding and the coefficient
//             address/data widths used as parameter defaults.
//  Revision : 1.0  initial release
// ============================================================================
package dsp_sched_pkg;

  localparam int COEF_ADDR_W = 8;
  localparam int COEF_DATA_W = 36;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_UPDATE = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. rdata always shows
//             the head entry; pop advances it. Push when full and pop when
//             empty are ignored. full/empty are registered alongside count.
//  Ports    : clk, rst_n (async, active low)
//             push, wdata       - write side
//             pop,  rdata       - read side (head entry)
//             full, empty, count - registered status
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/dsp_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_frame_scheduler
//  Purpose  : Starts the DSP core once per frame tick and owns the
//             coefficient-memory write port. Host writes are queued and
//             applied only in the gap after the core finishes, so a frame
//             never runs on partially updated coefficients.
//  Ports    : clk, rst_n (async, active low)
//             frame_tick              - one-cycle frame pulse
//             dsp_start / dsp_busy    - core handshake
//             req_valid/ready/addr/data - host write request
//             coef_we/addr/data       - coefficient memory write port
//             pending                 - queued write count
//             overrun, timed_out      - sticky flags; clear_flags clears
//  Revision : 1.0  initial release
// ============================================================================
module dsp_frame_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int ADDR_W     = COEF_ADDR_W,
  parameter int DATA_W     = COEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 2000,
  parameter int MAX_WR     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  output logic                          dsp_start,
  input  logic                          dsp_busy,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          coef_we,
  output logic [ADDR_W-1:0]             coef_addr,
  output logic [DATA_W-1:0]             coef_data,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overrun,
  output logic                          timed_out,
  input  logic                          clear_flags
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int WR_W  = $clog2(MAX_WR + 1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic              dsp_start_q, dsp_start_d;
  logic              coef_we_q, coef_we_d;
  logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
  logic [DATA_W-1:0] coef_data_q, coef_data_d;
  logic              overrun_q, overrun_d;
  logic              timed_out_q, timed_out_d;
  logic              set_overrun;
  logic              set_timeout;
  logic              pop;

  logic [ADDR_W+DATA_W-1:0]    fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .wdata ({req_addr, req_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    coef_addr_d = coef_addr_q;
    coef_data_d = coef_data_q;
    set_overrun = 1'b0;
    set_timeout = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_START;
      end
      ST_START: begin
        cyc_cnt_d   = '0;
        wr_cnt_d    = '0;
        set_overrun = frame_tick;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        set_overrun = frame_tick;
        cyc_cnt_d   = cyc_cnt_q + CNT_W'(1);
        // Counter >= 1 masks the cycle before busy is guaranteed to rise.
        if (!dsp_busy && (cyc_cnt_q != '0)) begin
          state_d = ST_UPDATE;
        end else if (cyc_cnt_q == CNT_W'(TIMEOUT)) begin
          set_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        // A new frame wins over pending writes; the rest wait for next gap.
        if (frame_tick) begin
          state_d = ST_START;
        end else if (fifo_empty || (wr_cnt_q == WR_W'(MAX_WR))) begin
          state_d = ST_IDLE;
        end else begin
          pop         = 1'b1;
          wr_cnt_d    = wr_cnt_q + WR_W'(1);
          coef_addr_d = fifo_rdata[DATA_W +: ADDR_W];
          coef_data_d = fifo_rdata[DATA_W-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dsp_start_d = (state_d == ST_START);
    coef_we_d   = pop;
    // Set takes priority over a simultaneous clear.
    overrun_d   = set_overrun | (overrun_q & ~clear_flags);
    timed_out_d = set_timeout | (timed_out_q & ~clear_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      dsp_start_q <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
      overrun_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      dsp_start_q <= dsp_start_d;
      coef_we_q   <= coef_we_d;
      coef_addr_q <= coef_addr_d;
      coef_data_q <= coef_data_d;
      overrun_q   <= overrun_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign dsp_start = dsp_start_q;
  assign coef_we   = coef_we_q;
  assign coef_addr = coef_addr_q;
  assign coef_data = coef_data_q;
  assign req_ready = ~fifo_full;
  assign pending   = fifo_count;
  assign overrun   = overrun_q;
  assign timed_out = timed_out_q;

endmodule
`default_nettype wire

// File: doc/dsp_frame_scheduler.md
# dsp_frame_scheduler

Sequences the DSP core once per audio frame and owns the DSP coefficient-memory write port. Host coefficient updates are queued in a small FIFO and written only in the idle gap after the core finishes a frame, so a frame never runs on half-updated coefficients. Sits on the oversampling clock between the (already synchronized) frame tick, the DSP core and the host control bridge.

## Interface
- `ADDR_W`, 8: coefficient address width
- `DATA_W`, 36: coefficient width (matches DSP word)
- `FIFO_DEPTH`, 8: pending-write queue depth (power of two, ≥2)
- `TIMEOUT`, 2000: max cycles allowed from `dsp_start` to busy falling
- `MAX_WR`, 16: max coefficient writes per frame gap

- `clk` in 1: oversampling clock, ~98.304 MHz
- `rst_n` in 1: asynchronous, active-low reset; one clock only
- `frame_tick` in 1: one-cycle pulse per sample frame, synchronous to `clk`
- `dsp_start` out 1: one-cycle start pulse to DSP core
- `dsp_busy` in 1: high while the core computes; rises ≤1 cycle after `dsp_start`
- `req_valid` in 1, `req_ready` out 1, `req_addr` in ADDR_W, `req_data` in DATA_W: host write request, valid/ready
- `coef_we` out 1, `coef_addr` out ADDR_W, `coef_data` out DATA_W: coefficient memory write port
- `pending` out $clog2(FIFO_DEPTH)+1: FIFO occupancy
- `overrun` out 1: sticky, tick arrived while frame in progress
- `timed_out` out 1: sticky, DSP exceeded `TIMEOUT`
- `clear_flags` in 1: clears both sticky flags

## Operation
- States: IDLE, START, RUN, UPDATE.
- IDLE: `frame_tick` → START.
- START (1 cycle): `dsp_start`=1; load cycle counter 0; → RUN.
- RUN: counter increments each cycle. Exit when `dsp_busy`=0 and counter ≥1 → UPDATE. Counter reaching `TIMEOUT` with busy still high → set `timed_out`, → IDLE (no writes this gap).
- UPDATE: each cycle with FIFO non-empty, write count < `MAX_WR` and no `frame_tick`, pop one entry. → IDLE when FIFO empty or `MAX_WR` pops done. `frame_tick` in UPDATE: no pop that cycle, → START directly; not an overrun.
- `frame_tick` in START or RUN: tick dropped, `overrun` set.
- FIFO: `req_ready` = not full; push on `req_valid & req_ready`. Push and pop in the same cycle are both honoured (occupancy unchanged). Entries are written in arrival order; no coalescing of equal addresses.
- Sticky flags: set has priority over `clear_flags` in the same cycle.

## Timing
- All outputs registered. Reset values: `dsp_start`=0, `coef_we`=0, `coef_addr`=0, `coef_data`=0, `req_ready`=1, `pending`=0, `overrun`=0, `timed_out`=0; state IDLE; FIFO empty.
- `frame_tick` sampled at cycle T in IDLE → `dsp_start` high at T+1 only.
- Pop at cycle P → `coef_we` high with that entry at P+1. Last write therefore precedes any subsequent `dsp_start` by ≥1 cycle; `coef_we` and `dsp_start` are never high together.
- Writes per gap back-to-back, one per cycle, ≤`MAX_WR`.
- `pending` reflects pushes/pops of the previous cycle.
- Reset asserted mid-frame or mid-UPDATE: immediate return to reset values, queued writes discarded, in-flight `coef_we` dropped.

## Structure
- Package `dsp_sched_pkg`: state enum, default widths `COEF_ADDR_W`/`COEF_DATA_W`.
- Sub-module `sync_fifo` (parameterized width/depth, full/empty/count, async active-low reset) holds `{addr,data}`; FSM, counters and flags in the top.

## Test plan
- Reset, then `frame_tick`, DSP model busy 100 cycles → `dsp_start` one cycle at T+1; no `coef_we`; `pending`=0.
- Push 3 writes (0x10/0x1, 0x11/0x2, 0x12/0x3) during RUN → after busy falls, 3 consecutive `coef_we` cycles in that order; none during busy.
- Push 20 writes, `MAX_WR`=16, `FIFO_DEPTH`=32 → 16 writes in gap 1, remaining 4 in gap 2; with depth 8, `req_ready` low after 8th push until first pop.
- `frame_tick` during RUN → `overrun`=1, no extra `dsp_start`; `clear_flags` → 0.
- Busy held high 2000 cycles → `timed_out`=1, FSM IDLE, queued writes remain (`pending` unchanged).
- `frame_tick` in UPDATE with 5 queued and 2 written → no pop that cycle, `dsp_start` next cycle, remaining 3 written in following gap; `rst_n` low mid-UPDATE → all outputs to reset values same cycle.
